// File: rtl/alu_arbiter_if.sv
// Requester/response handshake and ALU drive bundle for alu_arbiter.
// master = requesters plus the shared ALU; slave = the arbiter itself.
interface alu_arbiter_if #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
);
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [ILEN-1:0] req0_instr;
  logic [XLEN-1:0] req0_in1;
  logic [XLEN-1:0] req0_in2;
  logic [ILEN-1:0] req1_instr;
  logic [XLEN-1:0] req1_in1;
  logic [XLEN-1:0] req1_in2;
  logic [1:0]      resp_valid;
  logic [1:0]      resp_ready;
  logic [XLEN-1:0] resp_out;
  logic            resp_zero;
  logic [ILEN-1:0] alu_instruction;
  logic [XLEN-1:0] alu_in1;
  logic [XLEN-1:0] alu_in2;
  logic [XLEN-1:0] alu_out;
  logic            alu_zero;

  modport master (
    output req_valid, req0_instr, req0_in1, req0_in2,
           req1_instr, req1_in1, req1_in2, resp_ready, alu_out, alu_zero,
    input  req_ready, resp_valid, resp_out, resp_zero,
           alu_instruction, alu_in1, alu_in2
  );

  modport slave (
    input  req_valid, req0_instr, req0_in1, req0_in2,
           req1_instr, req1_in1, req1_in2, resp_ready, alu_out, alu_zero,
    output req_ready, resp_valid, resp_out, resp_zero,
           alu_instruction, alu_in1, alu_in2
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of one shared ALU.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 win every tie.
module alu_arbiter #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t          state_p1;
  state_t          state_nxt;
  logic            owner_p1;
  logic            rr_last_p1;
  logic [XLEN-1:0] res_p1;
  logic            zero_p1;

  logic            can_issue;
  logic            grant_any;
  logic            grant_idx;
  logic            sel;
  logic            drain;
  logic [ILEN-1:0] sel_instr;
  logic [XLEN-1:0] sel_in1;
  logic [XLEN-1:0] sel_in2;

  // Issue is allowed when the slot is empty or the held response drains now.
  always_comb begin
    drain     = (state_p1 == HOLD) && bus.resp_ready[owner_p1];
    can_issue = (state_p1 == IDLE) || drain;
    grant_any = 1'b0;
    grant_idx = 1'b0;
    if (rst_n && can_issue) begin
      case (bus.req_valid)
        2'b01: begin
          grant_any = 1'b1;
          grant_idx = 1'b0;
        end
        2'b10: begin
          grant_any = 1'b1;
          grant_idx = 1'b1;
        end
        2'b11: begin
          grant_any = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
          grant_idx = 1'b0;
`else
          grant_idx = ~rr_last_p1;
`endif
        end
        default: begin
          grant_any = 1'b0;
          grant_idx = 1'b0;
        end
      endcase
    end
  end

  // With no grant the ALU still sees a defined requester's fields.
  always_comb begin
    sel       = grant_any ? grant_idx : rr_last_p1;
    sel_instr = sel ? bus.req1_instr : bus.req0_instr;
    sel_in1   = sel ? bus.req1_in1   : bus.req0_in1;
    sel_in2   = sel ? bus.req1_in2   : bus.req0_in2;
  end

  assign bus.alu_instruction = sel_instr;
  assign bus.alu_in1         = sel_in1;
  assign bus.alu_in2         = sel_in2;

  always_comb begin
    state_nxt = state_p1;
    if (grant_any) begin
      state_nxt = HOLD;
    end else if (drain) begin
      state_nxt = IDLE;
    end
  end

  // ---- stage p1: response slot ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1   <= IDLE;
      owner_p1   <= 1'b0;
      rr_last_p1 <= 1'b1;
      res_p1     <= '0;
      zero_p1    <= 1'b0;
    end else begin
      state_p1 <= state_nxt;
      if (grant_any) begin
        res_p1     <= bus.alu_out;
        zero_p1    <= bus.alu_zero;
        owner_p1   <= grant_idx;
        rr_last_p1 <= grant_idx;
      end
    end
  end

  always_comb begin
    bus.req_ready  = 2'b00;
    bus.resp_valid = 2'b00;
    if (grant_any) begin
      bus.req_ready = grant_idx ? 2'b10 : 2'b01;
    end
    if (state_p1 == HOLD) begin
      bus.resp_valid = owner_p1 ? 2'b10 : 2'b01;
    end
  end

  assign bus.resp_out  = res_p1;
  assign bus.resp_zero = zero_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU, arbitration model and
// a result scoreboard filled at accept and drained at response handshake.
module tb_alu_arbiter;

  logic clk;
  logic rst_n;

  alu_arbiter_if #(.XLEN(64), .ILEN(32)) bus ();

  alu_arbiter #(.XLEN(64), .ILEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] alu_ref(input logic [31:0] ins,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
    logic [63:0] r;
    case (ins[14:12])
      3'd0: r = ins[30] ? (a - b) : (a + b);
      3'd1: r = a << b[5:0];
      3'd2: r = {63'd0, ($signed(a) < $signed(b))};
      3'd3: r = {63'd0, (a < b)};
      3'd4: r = a ^ b;
      3'd5: r = ins[30] ? 64'($signed(a) >>> b[5:0]) : (a >> b[5:0]);
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // Shared ALU stand-in
  always_comb begin
    bus.alu_out  = alu_ref(bus.alu_instruction, bus.alu_in1, bus.alu_in2);
    bus.alu_zero = (bus.alu_out == 64'd0);
  end

  typedef struct {
    logic [63:0] out;
    logic        zero;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic m_hold = 1'b0;
  logic m_owner = 1'b0;
  logic m_rr = 1'b1;
  logic last_grant_any;
  logic last_grant_idx;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: check combinational/registered outputs at negedge, then advance model.
  task automatic step();
    logic       can;
    logic       g_any;
    logic       g_idx;
    logic       drn;
    logic [1:0] exp_ready;
    logic [1:0] exp_vld;
    exp_t       e;
    @(negedge clk);
    drn   = m_hold && bus.resp_ready[m_owner];
    can   = !m_hold || drn;
    g_any = 1'b0;
    g_idx = 1'b0;
    if (rst_n && can && (bus.req_valid != 2'b00)) begin
      g_any = 1'b1;
      if (bus.req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        g_idx = 1'b0;
`else
        g_idx = ~m_rr;
`endif
      end else begin
        g_idx = bus.req_valid[1];
      end
    end
    exp_ready = g_any ? (g_idx ? 2'b10 : 2'b01) : 2'b00;
    exp_vld   = m_hold ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    chk("resp_valid", 64'(bus.resp_valid), 64'(exp_vld));
    if (m_hold && sb.size() > 0) begin
      chk("resp_out", bus.resp_out, sb[0].out);
      chk("resp_zero", 64'(bus.resp_zero), 64'(sb[0].zero));
    end
    @(posedge clk);
    last_grant_any = g_any;
    last_grant_idx = g_idx;
    if (!rst_n) begin
      m_hold = 1'b0;
      m_owner = 1'b0;
      m_rr   = 1'b1;
      sb.delete();
    end else begin
      if (drn && sb.size() > 0) void'(sb.pop_front());
      if (g_any) begin
        e.out  = g_idx ? alu_ref(bus.req1_instr, bus.req1_in1, bus.req1_in2)
                       : alu_ref(bus.req0_instr, bus.req0_in1, bus.req0_in2);
        e.zero = (e.out == 64'd0);
        sb.push_back(e);
        m_hold  = 1'b1;
        m_owner = g_idx;
        m_rr    = g_idx;
      end else if (drn) begin
        m_hold = 1'b0;
      end
    end
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [2:0] f3;
    logic       f7;
    f3 = 3'($urandom_range(0, 7));
    f7 = (f3 == 3'd0 || f3 == 3'd5) ? 1'($urandom_range(0, 1)) : 1'b0;
    return 32'h0000_0033 | (32'(f3) << 12) | (f7 ? 32'h4000_0000 : 32'h0);
  endfunction

  task automatic set_req(input logic idx, input logic [31:0] ins,
                         input logic [63:0] a, input logic [63:0] b);
    if (idx) begin
      bus.req1_instr = ins; bus.req1_in1 = a; bus.req1_in2 = b;
    end else begin
      bus.req0_instr = ins; bus.req0_in1 = a; bus.req0_in2 = b;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 2'b00;
    bus.resp_ready = 2'b00;
    set_req(1'b0, 32'h0, 64'd0, 64'd0);
    set_req(1'b1, 32'h0, 64'd0, 64'd0);

    do_reset();
    chk("rst_resp_out", bus.resp_out, 64'd0);
    chk("rst_resp_zero", 64'(bus.resp_zero), 64'd0);

    // single ADD on requester 0
    set_req(1'b0, 32'h0000_0033, 64'd5, 64'd7);
    bus.req_valid = 2'b01;
    step();
    bus.req_valid = 2'b00;
    chk("add_vld", 64'(bus.resp_valid), 64'h1);
    chk("add_out", bus.resp_out, 64'd12);
    chk("add_zero", 64'(bus.resp_zero), 64'd0);
    bus.resp_ready = 2'b01;
    step();
    bus.resp_ready = 2'b00;
    chk("add_drained", 64'(bus.resp_valid), 64'h0);
    step();

    // SUB to zero on requester 1
    set_req(1'b1, 32'h4000_0033, 64'd9, 64'd9);
    bus.req_valid = 2'b10;
    step();
    bus.req_valid = 2'b00;
    chk("sub_vld", 64'(bus.resp_valid), 64'h2);
    chk("sub_out", bus.resp_out, 64'd0);
    chk("sub_zero", 64'(bus.resp_zero), 64'd1);
    bus.resp_ready = 2'b10;
    step();
    bus.resp_ready = 2'b00;

    // SLT with negative operand on requester 1
    set_req(1'b1, 32'h0000_2033, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    bus.req_valid = 2'b10;
    step();
    bus.req_valid = 2'b00;
    chk("slt_out", bus.resp_out, 64'd1);
    chk("slt_zero", 64'(bus.resp_zero), 64'd0);
    bus.resp_ready = 2'b10;
    step();
    bus.resp_ready = 2'b00;

    // continuous contention from reset
    set_req(1'b0, rand_instr(), {$urandom, $urandom}, {$urandom, $urandom});
    set_req(1'b1, rand_instr(), {$urandom, $urandom}, {$urandom, $urandom});
    bus.req_valid  = 2'b11;
    bus.resp_ready = 2'b11;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step();
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk("cont_grant", 64'(last_grant_any && !last_grant_idx), 64'd1);
`else
      chk("cont_grant", 64'(last_grant_idx), 64'(i % 2));
`endif
      chk("cont_vld", 64'(bus.resp_valid != 2'b00), 64'd1);
      if (last_grant_any)
        set_req(last_grant_idx, rand_instr(), {$urandom, $urandom}, {$urandom, $urandom});
    end
    bus.req_valid = 2'b00;
    step();
    bus.resp_ready = 2'b00;
    step();

    // backpressure while requester 1 waits
    set_req(1'b0, 32'h0000_7033, 64'hF0, 64'h3C);
    bus.req_valid = 2'b01;
    step();
    set_req(1'b1, 32'h0000_0033, 64'd100, 64'd23);
    bus.req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_out", bus.resp_out, 64'h30);
    end
    bus.resp_ready = 2'b01;
    step();
    bus.req_valid = 2'b00;
    chk("bp_grant1", 64'(bus.resp_valid), 64'h2);
    chk("bp_out1", bus.resp_out, 64'd123);
    bus.resp_ready = 2'b10;
    step();
    bus.resp_ready = 2'b00;
    step();

    // reset while a response is held
    set_req(1'b0, 32'h0000_0033, 64'd1, 64'd2);
    bus.req_valid = 2'b01;
    step();
    bus.req_valid = 2'b00;
    step();
    rst_n = 1'b0;
    step();
    chk("midrst_vld", 64'(bus.resp_valid), 64'h0);
    chk("midrst_out", bus.resp_out, 64'd0);
    rst_n = 1'b1;
    set_req(1'b1, 32'h0000_6033, 64'h5, 64'hA);
    bus.req_valid = 2'b11;
    step();
    bus.req_valid = 2'b00;
    chk("midrst_tie", 64'(bus.resp_valid), 64'h1);
    bus.resp_ready = 2'b01;
    step();
    bus.resp_ready = 2'b00;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
